// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared parameters and state type for the FIFO drain packer
package fifo_pkg;

   localparam int SYM_W_DEFAULT = 2;
   localparam int SYMS_DEFAULT  = 4;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/pack_accumulator.sv
// rtl/pack_accumulator.sv - LSB-first symbol shift-in register with count and zero-padded word view
module pack_accumulator
   import fifo_pkg::*;
#(
   parameter int SYM_W = SYM_W_DEFAULT,
   parameter int SYMS  = SYMS_DEFAULT,
   localparam int CNT_W = $clog2(SYMS + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  shift_en,
   input  logic [SYM_W-1:0]      sym,
   output logic [CNT_W-1:0]      cnt,
   output logic [SYM_W*SYMS-1:0] word
);

   logic [SYM_W*SYMS-1:0] acc;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         acc <= '0;
         cnt <= '0;
      end else if (shift_en) begin
         for (int k = 0; k < SYMS; k++) begin
            if (cnt == CNT_W'(k))
               acc[k*SYM_W +: SYM_W] <= sym;
         end
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Slots at or above the count read as zero, so a flushed word is padded.
   always_comb begin
      word = '0;
      for (int k = 0; k < SYMS; k++) begin
         if (CNT_W'(k) < cnt)
            word[k*SYM_W +: SYM_W] = acc[k*SYM_W +: SYM_W];
      end
   end

endmodule

// File: rtl/fifo_drain_packer.sv
// rtl/fifo_drain_packer.sv - drains a registered-read FIFO and packs symbols into words
module fifo_drain_packer
   import fifo_pkg::*;
#(
   parameter int SYM_W = SYM_W_DEFAULT,
   parameter int SYMS  = SYMS_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   output logic                  fifo_r_en,
   input  logic [SYM_W-1:0]      fifo_data,
   input  logic                  flush,
   output logic [SYM_W*SYMS-1:0] word_data,
   output logic                  word_valid,
   input  logic                  word_ready,
   output logic                  word_partial
);

   localparam int CNT_W = $clog2(SYMS + 1);

   state_t           state;
   logic             rd_pending;
   logic             flush_req;
   logic [CNT_W-1:0] sym_cnt;
   logic             accept;
   logic             completes;

   assign accept    = (state == HOLD) && word_ready;
   assign completes = rd_pending && (sym_cnt == CNT_W'(SYMS - 1));

   pack_accumulator #(
      .SYM_W (SYM_W),
      .SYMS  (SYMS)
   ) u_acc (
      .clk      (clk),
      .rst      (rst),
      .clear    (accept),
      .shift_en (rd_pending),
      .sym      (fifo_data),
      .cnt      (sym_cnt),
      .word     (word_data)
   );

   // Reads are throttled so captured plus in-flight symbols never exceed one word.
   always_comb begin
      fifo_r_en = 1'b0;
      if (!rst && state == FILL && !fifo_empty && !flush_req)
         fifo_r_en = (int'(sym_cnt) + int'(rd_pending)) < SYMS;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= FILL;
         rd_pending   <= 1'b0;
         flush_req    <= 1'b0;
         word_valid   <= 1'b0;
         word_partial <= 1'b0;
      end else begin
         rd_pending <= fifo_r_en;
         case (state)
            FILL: begin
               if (completes) begin
                  state        <= HOLD;
                  word_valid   <= 1'b1;
                  word_partial <= 1'b0;
                  flush_req    <= 1'b0;
               end else if (flush_req && !rd_pending) begin
                  if (sym_cnt != '0) begin
                     state        <= HOLD;
                     word_valid   <= 1'b1;
                     word_partial <= 1'b1;
                  end else begin
                     flush_req <= 1'b0;
                  end
               end else if (flush) begin
                  flush_req <= 1'b1;
               end
            end
            HOLD: begin
               if (word_ready) begin
                  state        <= FILL;
                  word_valid   <= 1'b0;
                  word_partial <= 1'b0;
                  flush_req    <= 1'b0;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_drain_packer.sv
// tb/tb_fifo_drain_packer.sv - directed and randomized checks against a queue-based FIFO and packing model
module tb_fifo_drain_packer;
   import fifo_pkg::*;

   localparam int SYM_W  = SYM_W_DEFAULT;
   localparam int SYMS   = SYMS_DEFAULT;
   localparam int WORD_W = SYM_W * SYMS;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              fifo_empty = 1'b1;
   logic              fifo_r_en;
   logic [SYM_W-1:0]  fifo_data = '0;
   logic              flush = 1'b0;
   logic [WORD_W-1:0] word_data;
   logic              word_valid;
   logic              word_ready = 1'b0;
   logic              word_partial;

   int          errors = 0;
   int          checks = 0;
   int          q[$];
   int          exp_syms[$];
   logic [31:0] got[$];
   int          reads = 0;
   int          cyc = 0;
   int          first_rd = -1;
   int          last_rd = -1;
   int          gate_mode = 0;
   logic        gate = 1'b0;
   logic        take;
   logic        hold_prev = 1'b0;
   logic [31:0] prev_word = '0;

   always #5 clk = ~clk;

   fifo_drain_packer #(
      .SYM_W (SYM_W),
      .SYMS  (SYMS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_empty   (fifo_empty),
      .fifo_r_en    (fifo_r_en),
      .fifo_data    (fifo_data),
      .flush        (flush),
      .word_data    (word_data),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .word_partial (word_partial)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void upd_empty();
      fifo_empty = (q.size() == 0) || gate;
   endfunction

   // Upstream FIFO with a registered read port; non-read cycles present garbage data.
   always @(posedge clk) begin
      take = fifo_r_en && !fifo_empty;
      cyc++;
      if (take) begin
         reads++;
         if (first_rd < 0) first_rd = cyc;
         last_rd = cyc;
      end
      #1;
      if (take) fifo_data = SYM_W'(q.pop_front());
      else      fifo_data = SYM_W'($urandom);
      case (gate_mode)
         1:       gate = ~gate;
         2:       gate = 1'($urandom);
         default: gate = 1'b0;
      endcase
      upd_empty();
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (hold_prev) begin
            check("hold_valid", 32'(word_valid), 32'd1);
            check("hold_word", 32'({word_partial, word_data}), prev_word);
         end
         if (word_valid) check("no_read_in_hold", 32'(fifo_r_en), 32'd0);
         if (fifo_empty) check("no_read_when_empty", 32'(fifo_r_en), 32'd0);
         if (word_valid && word_ready) got.push_back(32'({word_partial, word_data}));
         hold_prev = word_valid && !word_ready;
         prev_word = 32'({word_partial, word_data});
      end else begin
         hold_prev = 1'b0;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic push(input int v);
      q.push_back(v);
      exp_syms.push_back(v);
      upd_empty();
   endtask

   task automatic wait_words(input int n, input int budget);
      int t = 0;
      while (got.size() < n && t < budget) begin
         step(1);
         t++;
      end
      check("word_timeout", 32'(got.size() >= n), 32'd1);
   endtask

   function automatic logic [31:0] next_got();
      if (got.size() == 0) return 32'hDEAD;
      return got.pop_front();
   endfunction

   // Reference packing: k-th symbol weighted by 2^(k*SYM_W), partial flag above the word.
   function automatic logic [31:0] model_word(input int n, input int partial);
      logic [31:0] w = 32'(partial) << WORD_W;
      for (int k = 0; k < n; k++)
         w = w + (32'(exp_syms.pop_front()) << (k * SYM_W));
      return w;
   endfunction

   initial begin
      int t;
      int base;
      int pushed;

      // Reset with a loaded FIFO: nothing may be read or presented.
      push(0); push(1); push(2); push(3);
      step(2);
      @(negedge clk);
      check("rst_valid", 32'(word_valid), 32'd0);
      check("rst_partial", 32'(word_partial), 32'd0);
      check("rst_data", 32'(word_data), 32'd0);
      check("rst_r_en", 32'(fifo_r_en), 32'd0);
      check("rst_reads", 32'(reads), 32'd0);
      step(1);

      // Four back-to-back reads then a full word E4.
      first_rd = -1;
      word_ready = 1'b1;
      rst = 1'b0;
      wait_words(1, 30);
      check("r030_reads", 32'(reads), 32'd4);
      check("r030_consecutive", 32'(last_rd - first_rd), 32'd3);
      check("r030_word", next_got(), 32'h0E4);
      exp_syms.delete();

      // Word held under backpressure, then a second word.
      got.delete();
      word_ready = 1'b0;
      push(3); push(3); push(3); push(3); push(1); push(0); push(0); push(2);
      t = 0;
      while (!word_valid && t < 30) begin step(1); t++; end
      check("r031_valid_seen", 32'(word_valid), 32'd1);
      base = reads;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("r031_hold_word", 32'({word_valid, word_partial, word_data}), 32'h2FF);
         step(1);
      end
      check("r031_no_reads", 32'(reads - base), 32'd0);
      word_ready = 1'b1;
      wait_words(2, 30);
      check("r031_first", next_got(), 32'h0FF);
      check("r031_second", next_got(), 32'h081);
      exp_syms.delete();

      // Two symbols then flush gives a zero-padded partial word.
      got.delete();
      push(2); push(1);
      step(6);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      wait_words(1, 20);
      check("r032_partial", next_got(), 32'h106);
      push(0); push(1); push(2); push(3);
      wait_words(1, 30);
      check("r032_after", next_got(), 32'h0E4);
      exp_syms.delete();

      // Flush with nothing gathered emits nothing.
      got.delete();
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      step(8);
      check("r033_no_word", 32'(got.size()), 32'd0);
      check("r033_idle_valid", 32'(word_valid), 32'd0);
      push(3); push(2); push(1); push(0);
      wait_words(1, 30);
      check("r033_next_full", next_got(), 32'h01B);
      exp_syms.delete();

      // Empty flag toggling every cycle.
      got.delete();
      gate_mode = 1;
      for (int i = 0; i < 2 * SYMS; i++) push(int'($urandom_range(0, (1 << SYM_W) - 1)));
      wait_words(2, 80);
      check("r034_word0", next_got(), model_word(SYMS, 0));
      check("r034_word1", next_got(), model_word(SYMS, 0));
      gate_mode = 0;
      step(2);

      // Reset with three captured and one read in flight; a queued fifth symbol waits.
      got.delete();
      exp_syms.delete();
      push(3); push(1); push(2); push(0); push(2);
      base = reads;
      t = 0;
      while (reads < base + 4 && t < 30) begin @(negedge clk); t++; end
      check("r035_reads_before", 32'(reads - base), 32'd4);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("r035_valid", 32'(word_valid), 32'd0);
      check("r035_partial", 32'(word_partial), 32'd0);
      check("r035_data", 32'(word_data), 32'd0);
      check("r035_r_en", 32'(fifo_r_en), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) void'(exp_syms.pop_front());
      step(1);
      push(1); push(3); push(0);
      wait_words(1, 30);
      step(10);
      check("r035_one_word", 32'(got.size()), 32'd1);
      check("r035_fresh", next_got(), 32'h036);
      check("r035_model", 32'h036, model_word(SYMS, 0));

      // Randomized traffic: random pushes, backpressure and empty gating.
      got.delete();
      exp_syms.delete();
      gate_mode = 2;
      pushed = 0;
      for (int i = 0; i < 400; i++) begin
         if (pushed < 8 * SYMS && $urandom_range(0, 2) == 0) begin
            push(int'($urandom_range(0, (1 << SYM_W) - 1)));
            pushed++;
         end
         word_ready = ($urandom_range(0, 3) != 0);
         step(1);
      end
      gate_mode = 0;
      word_ready = 1'b1;
      wait_words(8, 200);
      for (int w = 0; w < 8; w++) check("rand_word", next_got(), model_word(SYMS, 0));
      check("rand_extra", 32'(got.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
